gtxe2_chnl_rx_sync_ctrl: RTL and testbench

Comma-alignment sequencer for the GTXE2 RX channel model. Drives the comma-detect and comma-align enables of the RX byte aligner and consumes its comma-detect output plus the 8b/10b decoder error flag. Runs hunt, acquire, lock and loss-of-sync tracking, then freezes alignment once sync is declared. Sits between the RX aligner/decoder and the channel's status/ports logic.

---
 rtl/gtxe2_chnl_rx_sync_ctrl_if.sv | 28 ++
 rtl/gtxe2_chnl_rx_sync_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_gtxe2_chnl_rx_sync_ctrl.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/gtxe2_chnl_rx_sync_ctrl_if.sv
// Handshake bundle between the RX comma-alignment sequencer and its
// surroundings: aligner/decoder inputs, aligner controls and sync status.
interface gtxe2_chnl_rx_sync_ctrl_if;
    logic       enable;
    logic       comma_det;
    logic       code_err;
    logic       comma_det_en;
    logic       pcomma_align_en;
    logic       mcomma_align_en;
    logic       aligner_rst;
    logic       sync_ok;
    logic [1:0] sync_state;
    logic [7:0] loss_cnt;

    // Channel/status side: drives enable and aligner feedback, observes status.
    modport master (
        output enable, comma_det, code_err,
        input  comma_det_en, pcomma_align_en, mcomma_align_en,
        input  aligner_rst, sync_ok, sync_state, loss_cnt
    );

    // Sequencer side.
    modport slave (
        input  enable, comma_det, code_err,
        output comma_det_en, pcomma_align_en, mcomma_align_en,
        output aligner_rst, sync_ok, sync_state, loss_cnt
    );
endinterface

// File: rtl/gtxe2_chnl_rx_sync_ctrl.sv
// Comma-alignment sequencer for the GTXE2 RX channel model.
// Hunts for commas, acquires a run of them, declares sync and then freezes
// the aligner, tracking decode errors with a leaky error-credit counter.
module gtxe2_chnl_rx_sync_ctrl #(
    parameter int COMMA_ACQ_COUNT    = 3,
    parameter int ERR_LOSS_COUNT     = 4,
    parameter int GOOD_RECOVER_COUNT = 4,
    parameter int HUNT_TIMEOUT       = 1023,
    parameter int PCOMMA_EN          = 1,
    parameter int MCOMMA_EN          = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    gtxe2_chnl_rx_sync_ctrl_if.slave      bus
);

    // +1 keeps every counter at least one bit wide and able to hold the
    // incremented value that is compared against its terminal count.
    localparam int ACQ_W  = $clog2(COMMA_ACQ_COUNT + 1);
    localparam int ERR_W  = $clog2(ERR_LOSS_COUNT + 1);
    localparam int GOOD_W = $clog2(GOOD_RECOVER_COUNT + 1);
    localparam int TMR_W  = $clog2(HUNT_TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HUNT = 2'd1,
        ST_ACQ  = 2'd2,
        ST_SYNC = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [ACQ_W-1:0]    acq_cnt_q, acq_cnt_d;
    logic [ERR_W-1:0]    err_cnt_q, err_cnt_d;
    logic [GOOD_W-1:0]   good_cnt_q, good_cnt_d;
    logic [TMR_W-1:0]    timer_q, timer_d;
    logic [7:0]          loss_cnt_q, loss_cnt_d;
    logic                comma_det_en_q, comma_det_en_d;
    logic                pcomma_align_en_q, pcomma_align_en_d;
    logic                mcomma_align_en_q, mcomma_align_en_d;
    logic                aligner_rst_q, aligner_rst_d;
    logic                sync_ok_q, sync_ok_d;

    logic                enter_hunt;
    logic                aligning;
    logic [ACQ_W-1:0]    acq_inc;
    logic [ERR_W-1:0]    err_inc;
    logic [GOOD_W-1:0]   good_inc;
    logic [TMR_W-1:0]    timer_inc;

    assign acq_inc   = acq_cnt_q + ACQ_W'(1);
    assign err_inc   = err_cnt_q + ERR_W'(1);
    assign good_inc  = good_cnt_q + GOOD_W'(1);
    assign timer_inc = timer_q + TMR_W'(1);

    // Next-state, counter and registered-output computation.
    always_comb begin
        state_d    = state_q;
        acq_cnt_d  = acq_cnt_q;
        err_cnt_d  = err_cnt_q;
        good_cnt_d = good_cnt_q;
        timer_d    = timer_q;
        loss_cnt_d = loss_cnt_q;
        enter_hunt = 1'b0;

        if (!bus.enable) begin
            state_d    = ST_IDLE;
            acq_cnt_d  = '0;
            err_cnt_d  = '0;
            good_cnt_d = '0;
            timer_d    = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: enter_hunt = 1'b1;
                ST_HUNT: begin
                    if (bus.comma_det) begin
                        timer_d = '0;
                        if (COMMA_ACQ_COUNT == 1) begin
                            state_d    = ST_SYNC;
                            err_cnt_d  = '0;
                            good_cnt_d = '0;
                        end else begin
                            state_d   = ST_ACQ;
                            acq_cnt_d = ACQ_W'(1);
                        end
                    end else if (timer_inc == TMR_W'(HUNT_TIMEOUT)) begin
                        enter_hunt = 1'b1;
                    end else begin
                        timer_d = timer_inc;
                    end
                end
                ST_ACQ: begin
                    // A decode error means the candidate alignment is bad.
                    if (bus.code_err) begin
                        enter_hunt = 1'b1;
                    end else if (bus.comma_det) begin
                        timer_d = '0;
                        if (acq_inc == ACQ_W'(COMMA_ACQ_COUNT)) begin
                            state_d    = ST_SYNC;
                            err_cnt_d  = '0;
                            good_cnt_d = '0;
                        end else begin
                            acq_cnt_d = acq_inc;
                        end
                    end else if (timer_inc == TMR_W'(HUNT_TIMEOUT)) begin
                        enter_hunt = 1'b1;
                    end else begin
                        timer_d = timer_inc;
                    end
                end
                ST_SYNC: begin
                    if (bus.code_err) begin
                        good_cnt_d = '0;
                        if (err_inc == ERR_W'(ERR_LOSS_COUNT)) begin
                            enter_hunt = 1'b1;
                            if (loss_cnt_q != 8'hFF) begin
                                loss_cnt_d = loss_cnt_q + 8'd1;
                            end
                        end else begin
                            err_cnt_d = err_inc;
                        end
                    end else if (good_inc == GOOD_W'(GOOD_RECOVER_COUNT)) begin
                        good_cnt_d = '0;
                        if (err_cnt_q != '0) begin
                            err_cnt_d = err_cnt_q - ERR_W'(1);
                        end
                    end else begin
                        good_cnt_d = good_inc;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        // Every entry into HUNT restarts the aligner and all tracking counters.
        if (enter_hunt) begin
            state_d    = ST_HUNT;
            acq_cnt_d  = '0;
            err_cnt_d  = '0;
            good_cnt_d = '0;
            timer_d    = '0;
        end

        aligning          = (state_d == ST_HUNT) || (state_d == ST_ACQ);
        comma_det_en_d    = (state_d != ST_IDLE);
        pcomma_align_en_d = aligning && (PCOMMA_EN != 0);
        mcomma_align_en_d = aligning && (MCOMMA_EN != 0);
        aligner_rst_d     = enter_hunt;
        sync_ok_d         = (state_d == ST_SYNC);
    end

    // State, counter and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q           <= ST_IDLE;
            acq_cnt_q         <= '0;
            err_cnt_q         <= '0;
            good_cnt_q        <= '0;
            timer_q           <= '0;
            loss_cnt_q        <= '0;
            comma_det_en_q    <= 1'b0;
            pcomma_align_en_q <= 1'b0;
            mcomma_align_en_q <= 1'b0;
            aligner_rst_q     <= 1'b0;
            sync_ok_q         <= 1'b0;
        end else begin
            state_q           <= state_d;
            acq_cnt_q         <= acq_cnt_d;
            err_cnt_q         <= err_cnt_d;
            good_cnt_q        <= good_cnt_d;
            timer_q           <= timer_d;
            loss_cnt_q        <= loss_cnt_d;
            comma_det_en_q    <= comma_det_en_d;
            pcomma_align_en_q <= pcomma_align_en_d;
            mcomma_align_en_q <= mcomma_align_en_d;
            aligner_rst_q     <= aligner_rst_d;
            sync_ok_q         <= sync_ok_d;
        end
    end

    assign bus.comma_det_en    = comma_det_en_q;
    assign bus.pcomma_align_en = pcomma_align_en_q;
    assign bus.mcomma_align_en = mcomma_align_en_q;
    assign bus.aligner_rst     = aligner_rst_q;
    assign bus.sync_ok         = sync_ok_q;
    assign bus.sync_state      = state_q;
    assign bus.loss_cnt        = loss_cnt_q;

endmodule

// File: tb/tb_gtxe2_chnl_rx_sync_ctrl.sv
// Directed testbench for gtxe2_chnl_rx_sync_ctrl (default parameters).
module tb_gtxe2_chnl_rx_sync_ctrl;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;

    gtxe2_chnl_rx_sync_ctrl_if bus_if ();

    gtxe2_chnl_rx_sync_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            $display("check %s: %0d ok", tag, got);
        end
    endtask

    task automatic check_outs(input string tag, input int st, input int cde, input int pal,
                              input int mal, input int arst, input int sok, input int loss);
        check_eq({tag, ".state"},     32'(bus_if.sync_state),      32'(st));
        check_eq({tag, ".cdet_en"},   32'(bus_if.comma_det_en),    32'(cde));
        check_eq({tag, ".pcomma"},    32'(bus_if.pcomma_align_en), 32'(pal));
        check_eq({tag, ".mcomma"},    32'(bus_if.mcomma_align_en), 32'(mal));
        check_eq({tag, ".arst"},      32'(bus_if.aligner_rst),     32'(arst));
        check_eq({tag, ".sync_ok"},   32'(bus_if.sync_ok),         32'(sok));
        check_eq({tag, ".loss_cnt"},  32'(bus_if.loss_cnt),        32'(loss));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic comma_pulse();
        bus_if.comma_det = 1'b1;
        tick();
        bus_if.comma_det = 1'b0;
    endtask

    task automatic err_pulse();
        bus_if.code_err = 1'b1;
        tick();
        bus_if.code_err = 1'b0;
    endtask

    // From HUNT: acquire with three commas, then lose sync with four errors.
    task automatic do_loss();
        repeat (3) comma_pulse();
        repeat (4) err_pulse();
    endtask

    initial begin
        rst              = 1'b1;
        bus_if.enable    = 1'b0;
        bus_if.comma_det = 1'b0;
        bus_if.code_err  = 1'b0;
        #2;
        check_outs("reset", 0, 0, 0, 0, 0, 0, 0);
        tick();
        rst = 1'b0;
        tick();
        check_eq("idle_disabled.state", 32'(bus_if.sync_state), 32'd0);

        // Basic lock.
        bus_if.enable = 1'b1;
        tick();
        check_outs("hunt_entry", 1, 1, 1, 1, 1, 0, 0);
        tick();
        check_outs("hunt_2nd", 1, 1, 1, 1, 0, 0, 0);
        repeat (8) tick();
        comma_pulse();
        check_outs("acq_1", 2, 1, 1, 1, 0, 0, 0);
        repeat (9) tick();
        comma_pulse();
        check_eq("acq_2.state", 32'(bus_if.sync_state), 32'd2);
        repeat (9) tick();
        comma_pulse();
        check_outs("sync", 3, 1, 0, 0, 0, 1, 0);
        comma_pulse();
        check_eq("sync_comma_ignored.state", 32'(bus_if.sync_state), 32'd3);

        // Loss of sync: four errors two cycles apart.
        repeat (3) begin
            err_pulse();
            tick();
        end
        check_eq("loss_3err.state", 32'(bus_if.sync_state), 32'd3);
        err_pulse();
        check_outs("loss", 1, 1, 1, 1, 1, 0, 1);

        // Acquire abort and restart.
        comma_pulse();
        tick();
        comma_pulse();
        check_eq("abort_pre.state", 32'(bus_if.sync_state), 32'd2);
        err_pulse();
        check_outs("abort", 1, 1, 1, 1, 1, 0, 1);
        comma_pulse();
        check_eq("restart_1.state", 32'(bus_if.sync_state), 32'd2);
        comma_pulse();
        check_eq("restart_2.state", 32'(bus_if.sync_state), 32'd2);
        bus_if.comma_det = 1'b1;
        bus_if.code_err  = 1'b1;
        tick();
        bus_if.comma_det = 1'b0;
        bus_if.code_err  = 1'b0;
        check_eq("err_beats_comma.state", 32'(bus_if.sync_state), 32'd1);
        check_eq("err_beats_comma.arst", 32'(bus_if.aligner_rst), 32'd1);
        repeat (3) comma_pulse();
        check_eq("relock.state", 32'(bus_if.sync_state), 32'd3);

        // Recovery: 3 errors, 4 clean words retire one credit, 1 error -> still SYNC.
        repeat (3) err_pulse();
        check_eq("rec_3err.state", 32'(bus_if.sync_state), 32'd3);
        repeat (4) tick();
        err_pulse();
        check_eq("rec_hold.state", 32'(bus_if.sync_state), 32'd3);
        err_pulse();
        check_outs("rec_loss", 1, 1, 1, 1, 1, 0, 2);

        // Disable in SYNC, then re-enable.
        repeat (3) comma_pulse();
        check_eq("dis_pre.state", 32'(bus_if.sync_state), 32'd3);
        bus_if.enable = 1'b0;
        tick();
        check_outs("disable", 0, 0, 0, 0, 0, 0, 2);
        bus_if.enable = 1'b1;
        tick();
        check_outs("reenable", 1, 1, 1, 1, 1, 0, 2);

        // Hunt timeout period of 1023 cycles.
        repeat (1022) tick();
        check_outs("to_pre1", 1, 1, 1, 1, 0, 0, 2);
        tick();
        check_outs("to_pulse1", 1, 1, 1, 1, 1, 0, 2);
        repeat (1022) tick();
        check_eq("to_pre2.arst", 32'(bus_if.aligner_rst), 32'd0);
        tick();
        check_eq("to_pulse2.arst", 32'(bus_if.aligner_rst), 32'd1);
        check_eq("to_pulse2.state", 32'(bus_if.sync_state), 32'd1);

        // loss_cnt saturation.
        repeat (253) do_loss();
        check_eq("sat_255.loss_cnt", 32'(bus_if.loss_cnt), 32'd255);
        do_loss();
        check_eq("sat_hold.loss_cnt", 32'(bus_if.loss_cnt), 32'd255);
        check_eq("sat_hold.state", 32'(bus_if.sync_state), 32'd1);

        // Asynchronous reset in ACQUIRE, observed between clock edges.
        comma_pulse();
        check_outs("pre_arst", 2, 1, 1, 1, 0, 0, 255);
        #3;
        rst = 1'b1;
        #1;
        check_outs("async_rst", 0, 0, 0, 0, 0, 0, 0);
        tick();
        rst = 1'b0;
        tick();
        check_outs("post_rst", 1, 1, 1, 1, 1, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
